// File: rtl/alu_op_sequencer_if.sv
// Command/response handshake bundle for alu_op_sequencer.
//   cmd_valid/cmd_ready  command handshake; cmd_op/cmd_a/cmd_b carry the operation
//   rsp_valid/rsp_ready  response handshake; rsp_result/rsp_c/rsp_z/rsp_n/rsp_err carry the result
// master: the command issuer / response consumer; slave: the sequencer.
interface alu_op_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_result;
  logic       rsp_c;
  logic       rsp_z;
  logic       rsp_n;
  logic       rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_c, rsp_z, rsp_n, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_c, rsp_z, rsp_n, rsp_err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequential front-end for a 4-bit combinational ALU.
// Accepts one operation per command handshake, drives the ALU select/operand
// lines, waits SETTLE_CYCLES, captures the ALU result with C/Z/N flags and
// returns it through a response handshake. Sticky {C,Z,N} flags accumulate
// over all non-error captures until clr_sticky.
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   bus             command/response handshake (slave side)
//   alu_f/a/b       registered function select and operands to the ALU
//   alu_result/cout ALU output and adder carry-out
//   clr_sticky      clear sticky flags
//   sticky_flags    {C,Z,N} accumulated flags
module alu_op_sequencer #(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 4
) (
  input  logic                clk,
  input  logic                rst,
  alu_op_sequencer_if.slave   bus,
  output logic [2:0]          alu_f,
  output logic [3:0]          alu_a,
  output logic [3:0]          alu_b,
  input  logic [3:0]          alu_result,
  input  logic                alu_cout,
  input  logic                clr_sticky,
  output logic [2:0]          sticky_flags
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt;
  logic             legal;
  logic             accept;
  logic             accept_bad;
  logic             capture;
  logic             cap_c, cap_z, cap_n;

  assign legal = (bus.cmd_op <= 3'd4);

  // Carry is only meaningful for add/sub (f2:f1 == 00).
  assign cap_c = (alu_f[2:1] == 2'b00) & alu_cout;
  assign cap_z = (alu_result == 4'd0);
  assign cap_n = alu_result[3];

  always_comb begin
    state_d       = state;
    accept        = 1'b0;
    accept_bad    = 1'b0;
    capture       = 1'b0;
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state)
      S_IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          if (legal) begin
            accept  = 1'b1;
            state_d = S_WAIT;
          end else begin
            accept_bad = 1'b1;
            state_d    = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt == CNT_W'(1)) begin
          capture = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt            <= '0;
      alu_f          <= '0;
      alu_a          <= '0;
      alu_b          <= '0;
      bus.rsp_result <= '0;
      bus.rsp_c      <= 1'b0;
      bus.rsp_z      <= 1'b0;
      bus.rsp_n      <= 1'b0;
      bus.rsp_err    <= 1'b0;
      sticky_flags   <= '0;
    end else begin
      if (accept) begin
        alu_f <= bus.cmd_op;
        alu_a <= bus.cmd_a;
        alu_b <= bus.cmd_b;
        cnt   <= CNT_W'(SETTLE_CYCLES);
      end else if (state == S_WAIT) begin
        cnt <= cnt - CNT_W'(1);
      end

      if (accept_bad) begin
        bus.rsp_result <= '0;
        bus.rsp_c      <= 1'b0;
        bus.rsp_z      <= 1'b0;
        bus.rsp_n      <= 1'b0;
        bus.rsp_err    <= 1'b1;
      end else if (capture) begin
        bus.rsp_result <= alu_result;
        bus.rsp_c      <= cap_c;
        bus.rsp_z      <= cap_z;
        bus.rsp_n      <= cap_n;
        bus.rsp_err    <= 1'b0;
      end

      // Clear takes effect first so a same-edge capture still lands.
      sticky_flags <= (clr_sticky ? 3'b000 : sticky_flags) |
                      (capture ? {cap_c, cap_z, cap_n} : 3'b000);
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Shared stimulus; sel routes cmd_valid to DUT1 (SETTLE=1) or DUT3 (SETTLE=3).
  logic       sel = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd_op = '0;
  logic [3:0] cmd_a = '0;
  logic [3:0] cmd_b = '0;
  logic       rsp_ready = 1'b1;
  logic       clr_sticky = 1'b0;

  alu_op_sequencer_if if1 ();
  alu_op_sequencer_if if3 ();

  logic [2:0] alu_f1, alu_f3;
  logic [3:0] alu_a1, alu_b1, alu_a3, alu_b3;
  logic [3:0] alu_result1, alu_result3;
  logic       alu_cout1, alu_cout3;
  logic [2:0] sticky1, sticky3;

  assign if1.cmd_valid = cmd_valid & ~sel;
  assign if3.cmd_valid = cmd_valid & sel;
  assign if1.cmd_op = cmd_op;  assign if3.cmd_op = cmd_op;
  assign if1.cmd_a  = cmd_a;   assign if3.cmd_a  = cmd_a;
  assign if1.cmd_b  = cmd_b;   assign if3.cmd_b  = cmd_b;
  assign if1.rsp_ready = rsp_ready;
  assign if3.rsp_ready = rsp_ready;

  alu_op_sequencer #(.SETTLE_CYCLES(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .bus(if1),
    .alu_f(alu_f1), .alu_a(alu_a1), .alu_b(alu_b1),
    .alu_result(alu_result1), .alu_cout(alu_cout1),
    .clr_sticky(clr_sticky), .sticky_flags(sticky1)
  );

  alu_op_sequencer #(.SETTLE_CYCLES(3), .CNT_W(4)) dut3 (
    .clk(clk), .rst(rst), .bus(if3),
    .alu_f(alu_f3), .alu_a(alu_a3), .alu_b(alu_b3),
    .alu_result(alu_result3), .alu_cout(alu_cout3),
    .clr_sticky(clr_sticky), .sticky_flags(sticky3)
  );

  // Combinational ALU: f0 selects subtract (a + ~b + 1).
  function automatic logic [4:0] alu_model(input logic [2:0] f, input logic [3:0] a, b);
    logic [4:0] s;
    logic [3:0] r;
    s = {1'b0, a} + {1'b0, (f[0] ? ~b : b)} + {4'b0, f[0]};
    case (f)
      3'd0, 3'd1: r = s[3:0];
      3'd2:       r = a & b;
      3'd3:       r = a | b;
      3'd4:       r = ~a;
      default:    r = 4'd0;
    endcase
    return {s[4], r};
  endfunction

  assign {alu_cout1, alu_result1} = alu_model(alu_f1, alu_a1, alu_b1);
  assign {alu_cout3, alu_result3} = alu_model(alu_f3, alu_a3, alu_b3);

  // Observed signals of the selected DUT.
  logic       o_valid, o_ready;
  logic [7:0] o_rsp;
  logic [2:0] o_sticky, o_f;
  logic [3:0] o_a, o_b;
  always_comb begin
    if (sel) begin
      o_valid = if3.rsp_valid; o_ready = if3.cmd_ready;
      o_rsp = {if3.rsp_result, if3.rsp_c, if3.rsp_z, if3.rsp_n, if3.rsp_err};
      o_sticky = sticky3; o_f = alu_f3; o_a = alu_a3; o_b = alu_b3;
    end else begin
      o_valid = if1.rsp_valid; o_ready = if1.cmd_ready;
      o_rsp = {if1.rsp_result, if1.rsp_c, if1.rsp_z, if1.rsp_n, if1.rsp_err};
      o_sticky = sticky1; o_f = alu_f1; o_a = alu_a1; o_b = alu_b1;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t sel=%0d)", tag, got, exp, $time, sel);
    end
  endtask

  typedef struct packed {
    logic [3:0] r;
    logic       c, z, n, e;
    logic [2:0] st;
  } exp_t;

  exp_t       sb[$];
  logic [2:0] sticky_m [2];
  logic [2:0] last_f [2];
  logic [3:0] last_a [2];
  logic [3:0] last_b [2];

  task automatic model_reset();
    for (int unsigned i = 0; i < 2; i++) begin
      sticky_m[i] = '0; last_f[i] = '0; last_a[i] = '0; last_b[i] = '0;
    end
  endtask

  // Reference behaviour written arithmetically, independent of the ALU model.
  function automatic exp_t predict(input logic [2:0] op, input logic [3:0] a, b, input bit clr);
    exp_t e;
    int   ai, bi, ri;
    ai = int'(a); bi = int'(b);
    e = '0;
    case (op)
      3'd0: begin ri = ai + bi; e.c = (ri > 15); end
      3'd1: begin ri = ai - bi; e.c = (ai >= bi); end
      3'd2: ri = int'(a & b);
      3'd3: ri = int'(a | b);
      3'd4: ri = 15 - ai;
      default: begin ri = 0; e.e = 1'b1; end
    endcase
    e.r = 4'(ri & 15);
    if (!e.e) begin
      e.z = (e.r == 4'd0);
      e.n = e.r[3];
    end
    if (clr) begin sticky_m[0] = '0; sticky_m[1] = '0; end
    if (!e.e) begin
      sticky_m[sel] = sticky_m[sel] | {e.c, e.z, e.n};
      last_f[sel] = op; last_a[sel] = a; last_b[sel] = b;
    end
    e.st = sticky_m[sel];
    return e;
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [3:0] a, b,
                        input bit clr_cap, input int hold);
    exp_t e, got_e;
    int   lat, exp_lat;
    @(negedge clk);
    check("cmd_ready_idle", 32'(o_ready), 32'd1);
    e = predict(op, a, b, clr_cap);
    sb.push_back(e);
    exp_lat = e.e ? 0 : (sel ? 3 : 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    rsp_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("cmd_ready_busy", 32'(o_ready), 32'd0);
    if (clr_cap) clr_sticky = 1'b1;
    lat = 0;
    while (!o_valid && lat < 40) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    clr_sticky = 1'b0;
    check("latency", 32'(lat), 32'(exp_lat));
    if (sb.size() == 0) begin
      check("sb_nonempty", 32'd0, 32'd1);
      got_e = '0;
    end else begin
      got_e = sb.pop_front();
    end
    check("rsp", 32'(o_rsp), 32'({got_e.r, got_e.c, got_e.z, got_e.n, got_e.e}));
    check("sticky", 32'(o_sticky), 32'(got_e.st));
    check("alu_lines", 32'({o_f, o_a, o_b}), 32'({last_f[sel], last_a[sel], last_b[sel]}));
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1; cmd_op = 3'd0; cmd_a = 4'hf; cmd_b = 4'hf;
      @(posedge clk); @(negedge clk);
      check("hold_valid", 32'(o_valid), 32'd1);
      check("hold_rsp", 32'(o_rsp), 32'({got_e.r, got_e.c, got_e.z, got_e.n, got_e.e}));
      check("hold_cmd_ready", 32'(o_ready), 32'd0);
    end
    cmd_valid = 1'b0;
    if (hold > 0)
      check("hold_alu_a", 32'(o_a), 32'(last_a[sel]));
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rsp_drop", 32'(o_valid), 32'd0);
    check("ready_back", 32'(o_ready), 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_cmd_ready"}, 32'(o_ready), 32'd1);
    check({tag, "_rsp_valid"}, 32'(o_valid), 32'd0);
    check({tag, "_rsp"}, 32'(o_rsp), 32'd0);
    check({tag, "_alu"}, 32'({o_f, o_a, o_b}), 32'd0);
    check({tag, "_sticky"}, 32'(o_sticky), 32'd0);
  endtask

  initial begin
    bit saw_valid;
    model_reset();
    #2;
    sel = 1'b0; #1; check_reset_state("rst1");
    sel = 1'b1; #1; check_reset_state("rst3");
    sel = 1'b0;
    @(negedge clk); rst = 1'b0;

    // SETTLE_CYCLES=1 instance
    run_op(3'd0, 4'd6, 4'd4, 1'b0, 0);   // 10, N
    run_op(3'd1, 4'd7, 4'd5, 1'b0, 0);   // 2, C
    run_op(3'd0, 4'd7, 4'd9, 1'b0, 0);   // 0, C Z -> sticky 111
    @(negedge clk); clr_sticky = 1'b1;
    @(negedge clk); clr_sticky = 1'b0;
    sticky_m[0] = '0; sticky_m[1] = '0;
    check("clr_idle", 32'(o_sticky), 32'd0);
    run_op(3'd2, 4'd6, 4'd4, 1'b0, 0);   // 4
    run_op(3'd3, 4'd7, 4'd13, 1'b0, 0);  // 15, N
    run_op(3'd4, 4'd7, 4'd0, 1'b0, 0);   // 8, N
    run_op(3'd5, 4'd3, 4'd3, 1'b0, 0);   // illegal
    run_op(3'd7, 4'd1, 4'd2, 1'b0, 0);   // illegal
    run_op(3'd1, 4'd5, 4'd7, 1'b0, 0);   // 14, borrow
    run_op(3'd1, 4'd3, 4'd3, 1'b0, 0);   // 0, C Z
    run_op(3'd0, 4'd6, 4'd4, 1'b1, 0);   // clear on capture -> 001
    run_op(3'd0, 4'd1, 4'd2, 1'b0, 5);   // backpressure

    // SETTLE_CYCLES=3 instance
    sel = 1'b1;
    run_op(3'd0, 4'd7, 4'd9, 1'b0, 0);
    run_op(3'd1, 4'd2, 4'd9, 1'b0, 5);
    run_op(3'd6, 4'd2, 4'd2, 1'b0, 0);

    // Reset in the middle of WAIT
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd3; cmd_a = 4'd5; cmd_b = 4'd10;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("wait_busy", 32'(o_ready), 32'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_reset_state("midrst");
    @(negedge clk); rst = 1'b0;
    saw_valid = 1'b0;
    repeat (6) begin
      @(posedge clk); @(negedge clk);
      if (o_valid) saw_valid = 1'b1;
    end
    check("no_rsp_after_rst", 32'(saw_valid), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
